booth_iter_mul: RTL and testbench

//  Iterative, parametrised radix-4 Modified-Booth multiplier with valid/ready handshakes.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_digit_enc.sv | 36 +++
 rtl/booth_iter_mul.sv | 140 ++++++++++++++
 tb/tb_booth_iter_mul.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and size helpers for the iterative radix-4 Booth multiplier.
// No logic, no latency; provides the digit struct, FSM state type and the
// digit-count / cycle-count helpers used by booth_iter_mul and booth_digit_enc.
package booth_pkg;

  // One recoded radix-4 digit: magnitude select (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of radix-4 digits needed to cover an nbit operand in either mode.
  function automatic int npp(input int nbit);
    return (nbit + 2) / 2;
  endfunction

  // Number of BUSY cycles when k digits are consumed per cycle.
  function automatic int ncyc(input int nbit, input int k);
    return (npp(nbit) + k - 1) / k;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth digit encoder: triplet -> partial product and neg bit.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: triplet {b[2i+1],b[2i],b[2i-1]}; a_ext (NBIT+2, already extended);
//        pp = selected magnitude, one's complemented for negative digits; neg.
module booth_digit_enc
  import booth_pkg::*;
#(
  parameter int NBIT = 11
) (
  input  logic [2:0]      triplet,
  input  logic [NBIT+1:0] a_ext,
  output logic [NBIT+1:0] pp,
  output logic            neg
);

  booth_digit_t    dig;
  logic [NBIT+1:0] mag;

  always_comb begin
    dig = '0;
    case (triplet)
      3'b001, 3'b010: dig.one = 1'b1;
      3'b011:         dig.two = 1'b1;
      3'b100:         begin dig.neg = 1'b1; dig.two = 1'b1; end
      3'b101, 3'b110: begin dig.neg = 1'b1; dig.one = 1'b1; end
      default:        dig = '0;
    endcase
  end

  // a<<1 still fits in NBIT+2 bits for both signed and unsigned operands.
  assign mag = dig.one ? a_ext : (dig.two ? {a_ext[NBIT:0], 1'b0} : '0);
  // The +1 that completes the two's complement is added by the accumulator.
  assign pp  = dig.neg ? ~mag : mag;
  assign neg = dig.neg;

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier, PP_PER_CYCLE digits per clock, signed or unsigned.
// Latency: accept in cycle 0, BUSY for NCYC cycles, out_valid from cycle NCYC+1.
// Backpressure: product held in DONE until out_ready; in_ready = out_ready in DONE.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, signed_i;
//        out_valid/out_ready with product (2*NBIT bits).
module booth_iter_mul
  import booth_pkg::*;
#(
  parameter int NBIT         = 11,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NBIT-1:0]   a,
  input  logic [NBIT-1:0]   b,
  input  logic              signed_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NBIT-1:0] product
);

  localparam int K    = PP_PER_CYCLE;
  localparam int NPP  = npp(NBIT);
  localparam int NCYC = ncyc(NBIT, K);
  localparam int AW   = NBIT + 2;
  localparam int PW   = 2 * NBIT;
  localparam int ACCW = 2 * NBIT + 2;
  // b plus the implicit b[-1]=0 at bit 0, padded so every digit slot of every
  // batch can be shifted down without running off the vector.
  localparam int BXW  = 2 * NCYC * K + 1;
  localparam int IDXW = $clog2(NCYC * K + 1);

  state_t          state;
  logic [AW-1:0]   a_r;
  logic [BXW-1:0]  bx;
  logic [ACCW-1:0] acc;
  logic [IDXW-1:0] idx;

  logic [AW-1:0]   a_ext_c;
  logic [2*NPP-1:0] b_ext_c;
  logic            load;
  logic            last_batch;
  logic [ACCW-1:0] acc_next;

  logic [2:0]      trip [K];
  logic [AW-1:0]   pp   [K];
  logic            neg  [K];

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign load     = in_valid & in_ready;

  assign a_ext_c = signed_i ? {{2{a[NBIT-1]}}, a} : {2'b00, a};
  assign b_ext_c = signed_i ? {{(2*NPP-NBIT){b[NBIT-1]}}, b}
                            : {{(2*NPP-NBIT){1'b0}}, b};

  assign last_batch = (int'(idx) + K >= NPP);

  // Triplet selection; slots past the last real digit are forced to zero so a
  // sign-extended b does not leak a spurious digit into the final batch.
  always_comb begin
    logic [BXW-1:0] bsh;
    int             d;
    bsh = '0;
    d   = 0;
    for (int j = 0; j < K; j++) begin
      trip[j] = 3'b000;
      d       = int'(idx) + j;
      if (d < NPP) begin
        bsh     = bx >> (2 * d);
        trip[j] = bsh[2:0];
      end
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_enc
    booth_digit_enc #(.NBIT(NBIT)) u_enc (
      .triplet (trip[j]),
      .a_ext   (a_r),
      .pp      (pp[j]),
      .neg     (neg[j])
    );
  end

  // Sign-extend each partial product, add its neg bit at the same weight and
  // place it at 2^(2d); everything wraps modulo 2^ACCW.
  always_comb begin
    logic [ACCW-1:0] term;
    term     = '0;
    acc_next = acc;
    for (int j = 0; j < K; j++) begin
      term     = {{(ACCW-AW){pp[j][AW-1]}}, pp[j]} + {{(ACCW-1){1'b0}}, neg[j]};
      acc_next = acc_next + (term << (2 * (int'(idx) + j)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      idx       <= '0;
      a_r       <= '0;
      bx        <= '0;
    end else begin
      if (load) begin
        a_r <= a_ext_c;
        bx  <= BXW'({b_ext_c, 1'b0});
        acc <= '0;
        idx <= '0;
      end
      case (state)
        IDLE: begin
          if (in_valid) state <= BUSY;
        end
        BUSY: begin
          acc <= acc_next;
          if (last_batch) begin
            product   <= acc_next[PW-1:0];
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(K);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? BUSY : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_iter_mul.sv
// Self-checking bench for booth_iter_mul: four parameterisations, directed and
// random operands, backpressure, mid-operation reset, and an arithmetic model.
module tb_booth_iter_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] a = '0, b = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        sgn = 1'b0;
  logic [3:0]  iv = '0, ordy = 4'hF;
  wire  [3:0]  ir, ov;
  wire  [21:0] p0, p1, p2;
  wire  [15:0] p3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_iter_mul #(.NBIT(11), .PP_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b),
    .signed_i(sgn), .out_valid(ov[0]), .out_ready(ordy[0]), .product(p0));
  booth_iter_mul #(.NBIT(11), .PP_PER_CYCLE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b),
    .signed_i(sgn), .out_valid(ov[1]), .out_ready(ordy[1]), .product(p1));
  booth_iter_mul #(.NBIT(11), .PP_PER_CYCLE(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
    .signed_i(sgn), .out_valid(ov[2]), .out_ready(ordy[2]), .product(p2));
  booth_iter_mul #(.NBIT(8), .PP_PER_CYCLE(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a8), .b(b8),
    .signed_i(sgn), .out_valid(ov[3]), .out_ready(ordy[3]), .product(p3));

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer product of the operands interpreted per signedness, wrapped to 2*nbit.
  function automatic longint ref_mul(input longint x, input longint y, input int nbit, input bit s);
    longint m, xa, ya;
    m  = (longint'(1) << nbit) - 1;
    xa = x & m;
    ya = y & m;
    if (s && xa[nbit-1]) xa = xa - (m + 1);
    if (s && ya[nbit-1]) ya = ya - (m + 1);
    return (xa * ya) & ((longint'(1) << (2 * nbit)) - 1);
  endfunction

  function automatic logic [10:0] pick11();
    case ($urandom_range(0, 7))
      0:       return 11'h400;
      1:       return 11'h7FF;
      2:       return 11'h000;
      default: return 11'($urandom);
    endcase
  endfunction

  // Launch one operation on all four instances at once and check product and latency.
  task automatic op_all(input logic [10:0] xa, input logic [10:0] xb, input logic s,
                        input logic [7:0] ya, input logic [7:0] yb);
    int     lat [4];
    longint got [4];
    int     lat_exp [4];
    string  nm [4];
    lat_exp = '{6, 3, 2, 2};
    nm      = '{"k1", "k2", "k4", "n8k3"};
    for (int k = 0; k < 4; k++) begin lat[k] = 0; got[k] = 0; end
    a = xa; b = xb; a8 = ya; b8 = yb; sgn = s; ordy = 4'hF; iv = 4'hF;
    @(negedge clk);
    check("op_in_ready", longint'(ir), longint'(4'hF));
    @(posedge clk); #1;
    iv = 4'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ov[0] && lat[0] == 0) begin lat[0] = c; got[0] = longint'(p0); end
      if (ov[1] && lat[1] == 0) begin lat[1] = c; got[1] = longint'(p1); end
      if (ov[2] && lat[2] == 0) begin lat[2] = c; got[2] = longint'(p2); end
      if (ov[3] && lat[3] == 0) begin lat[3] = c; got[3] = longint'(p3); end
    end
    for (int k = 0; k < 4; k++) begin
      check({nm[k], "_lat"}, longint'(lat[k]), longint'(lat_exp[k]));
      if (k < 3) check({nm[k], "_prod"}, got[k], ref_mul(longint'(xa), longint'(xb), 11, s));
      else       check({nm[k], "_prod"}, got[k], ref_mul(longint'(ya), longint'(yb), 8, s));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [21:0] q [$];
    logic [21:0] exp_p;
    int          c, spur, sent, recv;
    logic        hs_in, hs_out;
    logic [21:0] pv;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(ir), longint'(4'hF));
    check("rst_out_valid", longint'(ov), 0);
    check("rst_p0", longint'(p0), 0);
    check("rst_p3", longint'(p3), 0);
    rst = 1'b0;

    // Directed corner cases across all parameterisations
    op_all(11'h7FF, 11'h7FF, 1'b0, 8'hFF, 8'hFF);
    check("t1_p0_const", longint'(p0), longint'(22'h3FF001));
    check("t1_p3_const", longint'(p3), longint'(16'd65025));
    op_all(11'h400, 11'h3FF, 1'b1, 8'h80, 8'h7F);
    check("t2_neg_const", longint'(p0), longint'(22'h300400));
    op_all(11'h7FF, 11'h7FF, 1'b1, 8'hFF, 8'hFF);
    check("t2_m1m1_const", longint'(p0), 1);
    op_all(11'd1000, 11'd1500, 1'b0, 8'd200, 8'd100);
    check("t5_k2_const", longint'(p1), 1500000);
    op_all(11'h400, 11'h400, 1'b1, 8'h80, 8'h80);
    for (int i = 0; i < 6; i++)
      op_all(pick11(), pick11(), 1'($urandom), 8'($urandom), 8'($urandom));

    // Backpressure hold in DONE, then back-to-back accept
    a = 11'd1234; b = 11'd567; sgn = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    c = 0;
    while (!ov[0] && c < 20) begin @(posedge clk); #1; c++; end
    check("bp_out_valid", longint'(ov[0]), 1);
    exp_p = 22'(ref_mul(1234, 567, 11, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", longint'(ov[0]), 1);
      check("bp_hold_prod", longint'(p0), longint'(exp_p));
      check("bp_hold_in_ready", longint'(ir[0]), 0);
    end
    a = 11'h5A5; b = 11'h1C3; sgn = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_in_ready_follows", longint'(ir[0]), 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp_valid_drop", longint'(ov[0]), 0);
    c = 0;
    while (!ov[0] && c < 20) begin @(posedge clk); #1; c++; end
    check("bp_next_lat", longint'(c), 6);
    check("bp_next_prod", longint'(p0), ref_mul(longint'(11'h5A5), longint'(11'h1C3), 11, 1'b1));
    @(posedge clk); #1;

    // Reset in BUSY cycle 3 aborts the operation
    a = 11'd777; b = 11'd333; sgn = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", longint'(ir[0]), 1);
    check("abort_out_valid", longint'(ov[0]), 0);
    check("abort_product", longint'(p0), 0);
    spur = 0;
    repeat (12) begin @(posedge clk); #1; if (ov != 4'h0) spur++; end
    check("abort_no_output", longint'(spur), 0);

    // Random stream with random backpressure on dut0
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 6000 && recv < 40; cyc++) begin
      if (!iv[0] && sent < 40 && $urandom_range(0, 3) != 0) begin
        a = pick11(); b = pick11(); sgn = 1'($urandom); iv[0] = 1'b1;
      end
      ordy[0] = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hs_in  = iv[0] & ir[0];
      hs_out = ov[0] & ordy[0];
      pv     = p0;
      @(posedge clk); #1;
      if (hs_in) begin
        q.push_back(22'(ref_mul(longint'(a), longint'(b), 11, sgn)));
        sent++;
        iv[0] = 1'b0;
      end
      if (hs_out) begin
        recv++;
        if (q.size() == 0) check("rand_extra_output", longint'(pv), -1);
        else               check("rand_prod", longint'(pv), longint'(q.pop_front()));
      end
    end
    check("rand_received", longint'(recv), 40);
    check("rand_pending", longint'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
